// File: rtl/time_set_if.sv
// time_set_if: button/enable inputs and counter-control/display outputs of time_set_ctrl
interface time_set_if;
  logic       mode_p;
  logic       up_p;
  logic       up_lvl;
  logic       en1hz;
  logic       run_en;
  logic       sec_clr;
  logic       min_inc;
  logic       hour_inc;
  logic       carry_inh;
  logic [1:0] mode;
  logic [5:0] blank;
  modport master (
    output mode_p, up_p, up_lvl, en1hz,
    input  run_en, sec_clr, min_inc, hour_inc, carry_inh, mode, blank
  );
  modport slave (
    input  mode_p, up_p, up_lvl, en1hz,
    output run_en, sec_clr, min_inc, hour_inc, carry_inh, mode, blank
  );
endinterface

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: RUN/SET_HOUR/SET_MIN mode control, auto-repeat increments and set-field blink; clk, async active-low rst, bus (slave)
module time_set_ctrl #(
  parameter int REPEAT_DLY = 25000000,
  parameter int REPEAT_PER = 5000000,
  parameter int BLINK_HALF = 12500000
) (
  input logic   clk,
  input logic   rst,
  time_set_if.slave bus
);
  localparam int RW = $clog2(REPEAT_DLY + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);
  typedef enum logic [1:0] {RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10, BAD = 2'b11} mode_t;
  mode_t         mode_q, mode_d;
  logic [RW-1:0] rpt_q, rpt_d, rpt_nxt;
  logic [BW-1:0] blk_q, blk_d;
  logic          phase_q, phase_d;
  logic          sec_clr_q, sec_clr_d;
  logic          min_inc_q, min_inc_d;
  logic          hour_inc_q, hour_inc_d;
  logic          carry_inh_q, carry_inh_d;
  logic [5:0]    blank_q, blank_d;
  logic          setting, chg, hold, fire, pulse, blk_tc;
  // rpt counts consecutive held cycles with the press cycle as 1; after a repeat
  // it restarts at REPEAT_DLY-REPEAT_PER so the next one lands REPEAT_PER later
  always_comb begin
    setting     = mode_q == SET_HOUR || mode_q == SET_MIN;
    chg         = bus.mode_p || mode_q == BAD;
    hold        = setting && !chg && bus.up_lvl;
    rpt_nxt     = rpt_q + 1'b1;
    fire        = hold && rpt_nxt == RW'(REPEAT_DLY);
    pulse       = setting && !chg && (bus.up_p || fire);
    rpt_d       = !hold ? '0 : bus.up_p ? RW'(1) : fire ? RW'(REPEAT_DLY - REPEAT_PER) : rpt_nxt;
    mode_d      = mode_q == BAD ? RUN : !bus.mode_p ? mode_q : mode_q == RUN ? SET_HOUR : mode_q == SET_HOUR ? SET_MIN : RUN;
    sec_clr_d   = bus.mode_p && mode_q == RUN;
    hour_inc_d  = pulse && mode_q == SET_HOUR;
    min_inc_d   = pulse && mode_q == SET_MIN;
    carry_inh_d = mode_d != RUN;
    blk_tc      = blk_q == BW'(BLINK_HALF - 1);
    blk_d       = (chg || pulse || blk_tc) ? '0 : blk_q + 1'b1;
    phase_d     = (chg || pulse) ? 1'b1 : phase_q ^ blk_tc;
    blank_d     = mode_d == SET_HOUR ? {{2{~phase_d}}, 4'b0} : mode_d == SET_MIN ? {2'b0, {2{~phase_d}}, 2'b0} : 6'b0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_q      <= RUN;
      rpt_q       <= '0;
      blk_q       <= '0;
      phase_q     <= 1'b1;
      sec_clr_q   <= 1'b0;
      min_inc_q   <= 1'b0;
      hour_inc_q  <= 1'b0;
      carry_inh_q <= 1'b0;
      blank_q     <= '0;
    end else begin
      mode_q      <= mode_d;
      rpt_q       <= rpt_d;
      blk_q       <= blk_d;
      phase_q     <= phase_d;
      sec_clr_q   <= sec_clr_d;
      min_inc_q   <= min_inc_d;
      hour_inc_q  <= hour_inc_d;
      carry_inh_q <= carry_inh_d;
      blank_q     <= blank_d;
    end
  end
  assign bus.run_en    = bus.en1hz && mode_q == RUN;
  assign bus.mode      = mode_q;
  assign bus.sec_clr   = sec_clr_q;
  assign bus.min_inc   = min_inc_q;
  assign bus.hour_inc  = hour_inc_q;
  assign bus.carry_inh = carry_inh_q;
  assign bus.blank     = blank_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: directed and randomized checks of time_set_ctrl against a cycle-level behavioural model
module tb_time_set_ctrl;
  localparam int DLY = 20;
  localparam int PER = 5;
  localparam int BH  = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int pass = 0;
  int total = 0;
  int m_mode, m_n, m_age;
  logic       run_s, e_run, e_sec, e_min, e_hour, e_ci;
  logic [1:0] e_mode;
  logic [5:0] e_blank;
  time_set_if bus ();
  time_set_ctrl #(.REPEAT_DLY(DLY), .REPEAT_PER(PER), .BLINK_HALF(BH)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic model_reset();
    m_mode = 0; m_n = 0; m_age = 0;
    e_mode = 2'b00; e_sec = 0; e_min = 0; e_hour = 0; e_ci = 0; e_blank = '0; e_run = 0;
  endtask
  // drive one cycle of inputs, advance the model, return #1 after the edge
  task automatic cyc(input logic mp, input logic up, input logic lv, input logic e1);
    logic pulse, fire, vis;
    @(negedge clk);
    bus.mode_p = mp; bus.up_p = up; bus.up_lvl = lv; bus.en1hz = e1;
    #1 run_s = bus.run_en;
    e_run = e1 && m_mode == 0;
    pulse = 0; fire = 0;
    if (m_mode != 0 && !mp) begin
      m_n = lv ? (up ? 1 : m_n + 1) : 0;
      fire = lv && m_n >= DLY && (m_n - DLY) % PER == 0;
      pulse = up || fire;
    end else m_n = 0;
    e_hour = pulse && m_mode == 1;
    e_min = pulse && m_mode == 2;
    e_sec = mp && m_mode == 0;
    m_age = (mp || pulse) ? 0 : m_age + 1;
    if (mp) m_mode = (m_mode + 1) % 3;
    vis = (m_age / BH) % 2 == 0;
    e_mode = 2'(m_mode);
    e_ci = m_mode != 0;
    e_blank = m_mode == 1 ? {{2{!vis}}, 4'b0} : m_mode == 2 ? {2'b0, {2{!vis}}, 2'b0} : 6'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    total++; if (bus.mode !== 2'b00 || bus.blank !== 6'b0) $display("FAIL reset_mode_blank: got %b/%b want 00/000000", bus.mode, bus.blank); else pass++;
    total++; if ({bus.sec_clr, bus.min_inc, bus.hour_inc, bus.carry_inh} !== 4'b0) $display("FAIL reset_pulses: got %b want 0000", {bus.sec_clr, bus.min_inc, bus.hour_inc, bus.carry_inh}); else pass++;
  endtask
  task automatic test_run();
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1);
      total++; if (run_s !== 1'b1) $display("FAIL run_en_high[%0d]: got %b want 1", i, run_s); else pass++;
      total++; if ({bus.mode, bus.min_inc, bus.hour_inc, bus.blank} !== 10'b0) $display("FAIL run_state[%0d]: got %b want 0", i, {bus.mode, bus.min_inc, bus.hour_inc, bus.blank}); else pass++;
      cyc(0, 0, 0, 0);
      total++; if (run_s !== 1'b0) $display("FAIL run_en_low[%0d]: got %b want 0", i, run_s); else pass++;
    end
  endtask
  task automatic test_mode_cycle();
    cyc(1, 0, 0, 0);
    total++; if ({bus.mode, bus.sec_clr, bus.carry_inh} !== 4'b0111) $display("FAIL enter_set_hour: got %b want 0111", {bus.mode, bus.sec_clr, bus.carry_inh}); else pass++;
    cyc(0, 0, 0, 1);
    total++; if ({run_s, bus.sec_clr} !== 2'b00) $display("FAIL set_gating: got %b want 00", {run_s, bus.sec_clr}); else pass++;
    cyc(1, 0, 0, 0);
    total++; if ({bus.mode, bus.sec_clr, bus.carry_inh} !== 4'b1001) $display("FAIL enter_set_min: got %b want 1001", {bus.mode, bus.sec_clr, bus.carry_inh}); else pass++;
    cyc(1, 0, 0, 0);
    total++; if ({bus.mode, bus.sec_clr, bus.carry_inh} !== 4'b0000) $display("FAIL back_to_run: got %b want 0000", {bus.mode, bus.sec_clr, bus.carry_inh}); else pass++;
  endtask
  task automatic test_single_inc();
    int extra = 0;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    total++; if ({bus.hour_inc, bus.min_inc} !== 2'b10) $display("FAIL hour_single: got %b want 10", {bus.hour_inc, bus.min_inc}); else pass++;
    for (int i = 0; i < 5; i++) begin cyc(0, 0, 0, 0); extra += bus.hour_inc + bus.min_inc; end
    total++; if (extra !== 0) $display("FAIL hour_no_extra: got %0d want 0", extra); else pass++;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    total++; if ({bus.hour_inc, bus.min_inc} !== 2'b01) $display("FAIL min_single: got %b want 01", {bus.hour_inc, bus.min_inc}); else pass++;
    cyc(0, 0, 0, 0);
    total++; if ({bus.hour_inc, bus.min_inc} !== 2'b00) $display("FAIL min_one_cycle: got %b want 00", {bus.hour_inc, bus.min_inc}); else pass++;
  endtask
  task automatic test_autorepeat();
    int n = 0;
    for (int j = 0; j < 45; j++) begin
      int c;
      logic want;
      cyc(0, j == 0, j < 40, 0);
      c = j + 1;
      want = c inside {1, 20, 25, 30, 35, 40};
      n += bus.min_inc;
      total++; if (bus.min_inc !== want || bus.hour_inc !== 1'b0) $display("FAIL repeat_cycle%0d: got min=%b hour=%b want min=%b hour=0", c, bus.min_inc, bus.hour_inc, want); else pass++;
    end
    total++; if (n !== 6) $display("FAIL repeat_count: got %0d want 6", n); else pass++;
  endtask
  task automatic test_blink();
    logic [1:0] want;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    total++; if (bus.mode !== 2'b01 || bus.blank !== 6'b0) $display("FAIL blink_start: got %b/%b want 01/000000", bus.mode, bus.blank); else pass++;
    for (int k = 1; k <= 32; k++) begin
      cyc(0, 0, 0, 0);
      want = ((k / BH) % 2) ? 2'b11 : 2'b00;
      total++; if (bus.blank !== {want, 4'b0}) $display("FAIL blink_c%0d: got %b want %b", k + 1, bus.blank, {want, 4'b0}); else pass++;
    end
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 0);
    total++; if (bus.blank !== 6'b110000) $display("FAIL blink_dark: got %b want 110000", bus.blank); else pass++;
    cyc(0, 1, 1, 0);
    total++; if (bus.blank !== 6'b0 || bus.hour_inc !== 1'b1) $display("FAIL blink_force_visible: got %b inc=%b want 000000 inc=1", bus.blank, bus.hour_inc); else pass++;
    cyc(0, 0, 0, 0);
  endtask
  task automatic test_collision();
    cyc(1, 1, 1, 0);
    total++; if ({bus.mode, bus.hour_inc, bus.min_inc} !== 4'b1000) $display("FAIL collision: got %b want 1000", {bus.mode, bus.hour_inc, bus.min_inc}); else pass++;
  endtask
  task automatic test_async_reset();
    cyc(0, 1, 1, 0);
    for (int j = 0; j < 24; j++) cyc(0, 0, 1, 0);
    total++; if (bus.min_inc !== 1'b1) $display("FAIL pre_reset_repeat: got %b want 1", bus.min_inc); else pass++;
    #2 rst = 1'b0;
    #1;
    total++; if ({bus.mode, bus.sec_clr, bus.min_inc, bus.hour_inc, bus.carry_inh, bus.blank} !== 12'b0) $display("FAIL async_reset: got %b want 0", {bus.mode, bus.sec_clr, bus.min_inc, bus.hour_inc, bus.carry_inh, bus.blank}); else pass++;
    bus.up_lvl = 0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int j = 0; j < 30; j++) cyc(0, 0, 0, 0);
    total++; if ({bus.mode, bus.min_inc, bus.hour_inc} !== 4'b0) $display("FAIL post_reset_idle: got %b want 0000", {bus.mode, bus.min_inc, bus.hour_inc}); else pass++;
  endtask
  task automatic test_random();
    int left = 0;
    for (int i = 0; i < 1500; i++) begin
      logic up;
      up = 0;
      if (left == 0 && $urandom_range(0, 7) == 0) begin left = $urandom_range(1, 45); up = 1; end
      cyc($urandom_range(0, 39) == 0, up, left > 0, $urandom_range(0, 3) == 0);
      if (left > 0) left--;
      total++; if (run_s !== e_run) $display("FAIL rand_run_en@%0d: got %b want %b", i, run_s, e_run); else pass++;
      total++; if ({bus.mode, bus.sec_clr, bus.min_inc, bus.hour_inc, bus.carry_inh, bus.blank} !== {e_mode, e_sec, e_min, e_hour, e_ci, e_blank})
        $display("FAIL rand_outputs@%0d: got %b want %b", i, {bus.mode, bus.sec_clr, bus.min_inc, bus.hour_inc, bus.carry_inh, bus.blank}, {e_mode, e_sec, e_min, e_hour, e_ci, e_blank});
      else pass++;
    end
  endtask
  initial begin
    bus.mode_p = 0; bus.up_p = 0; bus.up_lvl = 0; bus.en1hz = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    test_reset();
    test_run();
    test_mode_cycle();
    test_single_inc();
    test_autorepeat();
    test_blink();
    test_collision();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
